hamming_tx_serial: RTL
======================

# hamming_tx_serial

Upstream transmit stage for the Hamming(15,11) error-correction path. Accepts an 11-bit data word over a valid/ready handshake and computes the four parity bits. It then shifts the resulting 15-bit codeword out on a single serial line, framed by a start bit. The codeword bit order matches the 15-bit input layout of the downstream correction stage, so a receiver that deserializes the stream can present it directly to that stage.

## Interface
Parameters: none; frame format is fixed.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  synchronous reset, active-low; sampled on rising edge of clk
- dado_in  input  11  data word d10..d0 (bit 0 = d0)
- dado_valido  input  1  dado_in is valid this cycle
- pronto  output  1  block can accept a word this cycle; combinational: state OCIOSO and rst_n high
- serial_out  output  1  serial line, idle high
- palavra  output  15  registered codeword of the most recently accepted word
- ocupado  output  1  high during START and DADOS
- fim_quadro  output  1  one-cycle pulse in the cycle after the last code bit

## Operation
- Codeword layout, index i = codeword position i+1:
  - parity at indices 0, 1, 3, 7
  - data d0..d10 at indices 2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14
- Parity equations, even parity:
  - p[0] = XOR of indices 2,4,6,8,10,12,14
  - p[1] = XOR of 2,5,6,9,10,13,14
  - p[3] = XOR of 4,5,6,11,12,13,14
  - p[7] = XOR of 8..14
- Parity is computed combinationally from dado_in. The full codeword is captured into palavra on acceptance. Later changes on dado_in have no effect on a frame in progress.
- Acceptance: dado_valido and pronto high at a rising edge. dado_valido while pronto is low is ignored; the producer must hold it.
- FSM states:
  - OCIOSO: serial_out=1. On acceptance, go to START.
  - START: serial_out=0 for 1 cycle, then go to DADOS with bit counter = 0.
  - DADOS: serial_out=palavra[contador]; counter runs 0..14, LSB first. When the counter reaches 14, go to OCIOSO next cycle.
- fim_quadro is registered and goes high in the first OCIOSO cycle after DADOS. That cycle is also the stop/idle bit.
- A new word may be accepted in that same cycle.
- The bit counter is 4 bits. Values 15 and above are never reached; the exit is from 14 only.

## Timing
- Reset (rst_n low at an edge):
  - state OCIOSO
  - serial_out=1, ocupado=0, fim_quadro=0, palavra=0, counter=0
  - pronto=0 while rst_n is low
- Reset mid-frame aborts immediately. The line returns high on the next cycle, no fim_quadro is issued, and the partial frame is discarded.
- Accept at edge T:
  - START occupies cycle T+1
  - code bit k is driven in cycle T+2+k, for k=0..14
  - fim_quadro pulses in cycle T+17
- Minimum frame period is 17 cycles: 1 start bit + 15 code bits + 1 idle bit.
- pronto is low from T+1 through T+16 and high at T+17.
- ocupado is high from T+1 through T+16.
- palavra is updated at edge T and is visible from T+1. It holds its value until the next acceptance.

## Test plan
- Reset, then dado_in=11'h000 accepted:
  - palavra=15'h0000
  - serial shows 0 start bit then 15 zeros
  - fim_quadro at T+17
  - line stays 1 afterwards
- dado_in=11'h7FF → palavra=15'h7FFF; serial shows start bit then 15 ones.
- dado_in=11'h001 → palavra=15'h0007; dado_in=11'h400 → palavra=15'h408B. Check serial order LSB first against palavra bit by bit.
- Back-to-back: dado_valido held high with 11'h001 then 11'h400:
  - second acceptance occurs exactly in the fim_quadro cycle
  - second start bit at T+18
  - dado_in changes during frame 1 do not corrupt it
- rst_n low during DADOS (bit 6):
  - next cycle serial_out=1, ocupado=0, palavra=0
  - no fim_quadro
  - new frame accepted normally after release
- Loopback: random 500 words serialized, deserialized by a bench model, and fed to the downstream correction stage.
  - With 0 errors, the corrector output equals dado_in.
  - With any single flipped serial bit, the corrector output equals dado_in.

Source files
------------

// File: rtl/hamming_tx_serial.sv
// rtl/hamming_tx_serial.sv - Hamming(15,11) encoder with start-bit framed serial transmitter
module hamming_tx_serial (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] dado_in,
  input  logic        dado_valido,
  output logic        pronto,
  output logic        serial_out,
  output logic [14:0] palavra,
  output logic        ocupado,
  output logic        fim_quadro
);

  typedef enum logic [1:0] {OCIOSO, START, DADOS} estado_t;

  estado_t     estado;
  logic [3:0]  contador;
  logic [14:0] dados_pos;
  logic [14:0] codigo;

  // Data bits occupy the non-power-of-two positions; parity slots start at zero.
  assign dados_pos = {dado_in[10:4], 1'b0, dado_in[3:1], 1'b0, dado_in[0], 2'b00};

  always_comb begin
    codigo    = dados_pos;
    codigo[0] = ^{dados_pos[2], dados_pos[4], dados_pos[6], dados_pos[8],
                  dados_pos[10], dados_pos[12], dados_pos[14]};
    codigo[1] = ^{dados_pos[2], dados_pos[5], dados_pos[6], dados_pos[9],
                  dados_pos[10], dados_pos[13], dados_pos[14]};
    codigo[3] = ^{dados_pos[4], dados_pos[5], dados_pos[6], dados_pos[11],
                  dados_pos[12], dados_pos[13], dados_pos[14]};
    codigo[7] = ^dados_pos[14:8];
  end

  assign pronto = (estado == OCIOSO) && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado     <= OCIOSO;
      contador   <= '0;
      palavra    <= '0;
      serial_out <= 1'b1;
      ocupado    <= 1'b0;
      fim_quadro <= 1'b0;
    end else begin
      fim_quadro <= 1'b0;
      case (estado)
        OCIOSO: begin
          serial_out <= 1'b1;
          if (dado_valido) begin
            palavra    <= codigo;
            estado     <= START;
            serial_out <= 1'b0;
            ocupado    <= 1'b1;
          end
        end
        START: begin
          estado     <= DADOS;
          contador   <= '0;
          serial_out <= palavra[0];
        end
        DADOS: begin
          if (contador == 4'd14) begin
            estado     <= OCIOSO;
            contador   <= '0;
            serial_out <= 1'b1;
            ocupado    <= 1'b0;
            fim_quadro <= 1'b1;
          end else begin
            contador   <= contador + 4'd1;
            serial_out <= palavra[contador + 4'd1];
          end
        end
        default: begin
          estado     <= OCIOSO;
          serial_out <= 1'b1;
          ocupado    <= 1'b0;
        end
      endcase
    end
  end

endmodule
